// File: rtl/xpb_seq_ctrl.sv
// XPB table sequencer: issues one lookup per index chunk of a job and sums
// the returned table entries at full precision.
module xpb_seq_ctrl #(
  parameter  int NUM_CHUNKS = 8,
  parameter  int IDX_W      = 5,
  parameter  int DATA_W     = 1024,
  localparam int SEL_W      = $clog2(NUM_CHUNKS),
  localparam int ACC_W      = DATA_W + $clog2(NUM_CHUNKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CHUNKS*IDX_W-1:0] in_bits,
  output logic                        lut_en,
  output logic [SEL_W-1:0]            lut_sel,
  output logic [IDX_W-1:0]            lut_idx,
  input  logic [DATA_W-1:0]           lut_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_sum,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam logic [SEL_W-1:0] K_LAST = SEL_W'(NUM_CHUNKS - 1);

  state_e                        state_q, state_d;
  logic [SEL_W-1:0]              k_q, k_d;
  logic [NUM_CHUNKS*IDX_W-1:0]   bits_q, bits_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic                          en_d1_q, en_d1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      bits_q  <= '0;
      acc_q   <= '0;
      en_d1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bits_q  <= bits_d;
      acc_q   <= acc_d;
      en_d1_q <= en_d1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bits_d    = bits_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    lut_en    = 1'b0;
    lut_sel   = '0;
    lut_idx   = '0;
    out_valid = 1'b0;
    out_sum   = '0;

    // Table output lags its issue by one cycle, so add on the delayed enable.
    if (en_d1_q) begin
      acc_d = acc_q + ACC_W'(lut_data);
    end

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bits_d  = in_bits;
          acc_d   = '0;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lut_en  = 1'b1;
        lut_sel = k_q;
        lut_idx = bits_q[int'(k_q)*IDX_W +: IDX_W];
        k_d     = k_q + SEL_W'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = acc_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d1_d = lut_en;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_xpb_seq_ctrl.sv
// Directed bench for xpb_seq_ctrl: registered LUT model, per-cycle checks of
// the issue pattern, latency, output hold, reset abort and input capture.
module tb_xpb_seq_ctrl;

  localparam int NUM_CHUNKS = 8;
  localparam int IDX_W      = 5;
  localparam int DATA_W     = 1024;
  localparam int SEL_W      = 3;
  localparam int ACC_W      = 1027;
  localparam int BITS_W     = NUM_CHUNKS * IDX_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [BITS_W-1:0] in_bits;
  logic              lut_en;
  logic [SEL_W-1:0]  lut_sel;
  logic [IDX_W-1:0]  lut_idx;
  logic [DATA_W-1:0] lut_data = '0;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int lut_mode = 0;

  xpb_seq_ctrl #(
    .NUM_CHUNKS(NUM_CHUNKS),
    .IDX_W     (IDX_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bits  (in_bits),
    .lut_en   (lut_en),
    .lut_sel  (lut_sel),
    .lut_idx  (lut_idx),
    .lut_data (lut_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] lut_fn(input logic [SEL_W-1:0] sel,
                                               input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    case (lut_mode)
      0: v = (idx == 0) ? '0 : DATA_W'(32'hBAD0BAD0);
      1: v = (sel == 3 && idx == 1) ? DATA_W'(16'h1234) : '0;
      2: v = '1;
      default: v = DATA_W'(idx) << (8 * int'(sel));
    endcase
    return v;
  endfunction

  // Registered table; a junk pattern appears whenever no lookup was issued.
  always @(posedge clk) begin
    if (lut_en) lut_data <= lut_fn(lut_sel, lut_idx);
    else        lut_data <= {32{32'hDEADBEEF}};
  end

  task automatic check(input string tag, input logic [ACC_W-1:0] obs,
                       input logic [ACC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      if ((obs >> 400) == 0 && (exp >> 400) == 0)
        $error("FAIL %s actual=%0h required=%0h", tag, obs, exp);
      else
        $error("FAIL %s actual_hi=%h actual_lo=%h required_hi=%h required_lo=%h",
               tag, obs[ACC_W-1:ACC_W-128], obs[127:0], exp[ACC_W-1:ACC_W-128], exp[127:0]);
    end
  endtask

  // Call at the falling edge of c0. delay = cycles out_ready stays low after
  // out_valid rises (0 means out_ready is already high). hold keeps in_valid
  // high with scrambled in_bits for the whole job.
  task automatic run_job(input string tag, input logic [BITS_W-1:0] bits,
                         input int delay, input logic [ACC_W-1:0] exp_sum,
                         input bit hold);
    int  c;
    bit  done;
    bit  en_exp;
    logic [IDX_W-1:0] idx_exp;
    check({tag, "/in_ready_c0"}, ACC_W'(in_ready), ACC_W'(1));
    in_valid  = 1'b1;
    in_bits   = bits;
    out_ready = (delay == 0);
    c    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      c++;
      in_valid = hold;
      if (hold) in_bits = {$urandom, $urandom};
      en_exp  = (c >= 1 && c <= NUM_CHUNKS);
      idx_exp = '0;
      if (en_exp) idx_exp = bits[(c-1)*IDX_W +: IDX_W];
      check($sformatf("%s/lut_en_c%0d", tag, c), ACC_W'(lut_en), ACC_W'(en_exp));
      check($sformatf("%s/lut_sel_c%0d", tag, c), ACC_W'(lut_sel), en_exp ? ACC_W'(c-1) : '0);
      check($sformatf("%s/lut_idx_c%0d", tag, c), ACC_W'(lut_idx), ACC_W'(idx_exp));
      check($sformatf("%s/out_valid_c%0d", tag, c), ACC_W'(out_valid), ACC_W'(c >= 10));
      check($sformatf("%s/out_sum_c%0d", tag, c), out_sum, (c >= 10) ? exp_sum : '0);
      check($sformatf("%s/in_ready_c%0d", tag, c), ACC_W'(in_ready), '0);
      check($sformatf("%s/busy_c%0d", tag, c), ACC_W'(busy), ACC_W'(1));
      if (c >= 10 + delay) begin
        out_ready = 1'b1;
        done = 1;
      end
      if (c > 40) begin
        check({tag, "/timeout"}, ACC_W'(c), ACC_W'(10 + delay));
        done = 1;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/in_ready_after"}, ACC_W'(in_ready), ACC_W'(1));
    check({tag, "/busy_after"}, ACC_W'(busy), '0);
    check({tag, "/out_valid_after"}, ACC_W'(out_valid), '0);
    check({tag, "/out_sum_after"}, out_sum, '0);
    $display("job %s finished: handshake at c%0d", tag, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] all_ones_sum;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = '0;
    out_ready = 1'b0;

    // Reset values while rst_n is held low.
    #12;
    check("reset/in_ready", ACC_W'(in_ready), ACC_W'(1));
    check("reset/busy", ACC_W'(busy), '0);
    check("reset/lut_en", ACC_W'(lut_en), '0);
    check("reset/lut_sel", ACC_W'(lut_sel), '0);
    check("reset/lut_idx", ACC_W'(lut_idx), '0);
    check("reset/out_valid", ACC_W'(out_valid), '0);
    check("reset/out_sum", out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero chunks, out_ready already high: result 0 at c10.
    lut_mode = 0;
    run_job("zero", '0, 0, '0, 1'b0);

    // Only chunk 3 = 1; table3[1] = 0x1234.
    lut_mode = 1;
    run_job("single", {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0}, 0,
            ACC_W'(16'h1234), 1'b0);

    // Every entry all ones: 8*(2^1024-1) = 2^1027 - 8.
    lut_mode = 2;
    all_ones_sum = {ACC_W{1'b1}} << 3;
    run_job("allones", {BITS_W{1'b1}}, 0, all_ones_sum, 1'b0);

    // Byte-lane table: chunk k lands in byte k; out_ready withheld 5 cycles.
    lut_mode = 3;
    run_job("backpressure", {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 5,
            ACC_W'(64'h0807060504030201), 1'b0);

    // Abort a job with a reset pulse in c5.
    in_valid = 1'b1;
    in_bits  = {5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/lut_en", ACC_W'(lut_en), '0);
    check("abort/out_valid", ACC_W'(out_valid), '0);
    check("abort/busy", ACC_W'(busy), '0);
    check("abort/in_ready", ACC_W'(in_ready), ACC_W'(1));
    check("abort/out_sum", out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("abort/no_out_valid_%0d", i), ACC_W'(out_valid), '0);
    end
    $display("job abort finished: reset in c5");
    run_job("after_abort", {5'd5, 5'd30, 5'd9, 5'd0, 5'd2, 5'd17, 5'd0, 5'd31}, 0,
            ACC_W'(64'h051E09000211001F), 1'b0);

    // in_valid stays high with churning in_bits; next job starts right after.
    run_job("hold_first", {5'd3, 5'd0, 5'd31, 5'd12, 5'd0, 5'd1, 5'd20, 5'd6}, 2,
            ACC_W'(64'h03001F0C00011406), 1'b1);
    run_job("hold_second", {5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd16}, 0,
            ACC_W'(64'h020406080A0C0E10), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
